// File: rtl/axi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : axi_mem_responder
// Brief    : AXI4 INCR-burst slave backed by a word-addressed dual-port RAM.
// Revision : 1.0
// ============================================================================
module axi_mem_responder #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        S_AXI_AWID,
    input  logic [31:0] S_AXI_AWADDR,
    input  logic [7:0]  S_AXI_AWLEN,
    input  logic [2:0]  S_AXI_AWSIZE,
    input  logic [1:0]  S_AXI_AWBURST,
    input  logic        S_AXI_AWVALID,
    output logic        S_AXI_AWREADY,
    input  logic [31:0] S_AXI_WDATA,
    input  logic [3:0]  S_AXI_WSTRB,
    input  logic        S_AXI_WLAST,
    input  logic        S_AXI_WVALID,
    output logic        S_AXI_WREADY,
    output logic        S_AXI_BID,
    output logic [1:0]  S_AXI_BRESP,
    output logic        S_AXI_BVALID,
    input  logic        S_AXI_BREADY,
    input  logic        S_AXI_ARID,
    input  logic [31:0] S_AXI_ARADDR,
    input  logic [7:0]  S_AXI_ARLEN,
    input  logic [2:0]  S_AXI_ARSIZE,
    input  logic [1:0]  S_AXI_ARBURST,
    input  logic        S_AXI_ARVALID,
    output logic        S_AXI_ARREADY,
    output logic        S_AXI_RID,
    output logic [31:0] S_AXI_RDATA,
    output logic [1:0]  S_AXI_RRESP,
    output logic        S_AXI_RLAST,
    output logic        S_AXI_RVALID,
    input  logic        S_AXI_RREADY
);
    localparam int unsigned IDX_W    = $clog2(MEM_WORDS);
    localparam logic [31:0] WORDS_32 = 32'(MEM_WORDS);

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_e;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_FETCH = 2'd1, R_DATA = 2'd2} rstate_e;

    logic [31:0] mem [MEM_WORDS];
    logic [31:0] mem_rd_q;

    wstate_e     w_state_q, w_state_d;
    logic        awready_q;
    logic        w_id_q, w_id_d;
    logic [31:0] w_addr_q, w_addr_d;
    logic [7:0]  w_len_q, w_len_d;
    logic [8:0]  w_cnt_q, w_cnt_d;
    logic        w_berr_q, w_berr_d;
    logic        w_slverr_q, w_slverr_d;
    logic        w_we;
    logic [31:0] w_off;
    logic        w_in_range;

    rstate_e     r_state_q, r_state_d;
    logic        arready_q;
    logic        r_id_q, r_id_d;
    logic [31:0] r_addr_q, r_addr_d;
    logic [7:0]  r_len_q, r_len_d;
    logic [7:0]  r_cnt_q, r_cnt_d;
    logic        r_berr_q, r_berr_d;
    logic        r_ok_q, r_ok_d;
    logic [31:0] r_off;
    logic        r_in_range;

    assign w_off      = w_addr_q - BASE_ADDR;
    assign w_in_range = (w_addr_q >= BASE_ADDR) && ((w_off >> 2) < WORDS_32);
    assign r_off      = r_addr_q - BASE_ADDR;
    assign r_in_range = (r_addr_q >= BASE_ADDR) && ((r_off >> 2) < WORDS_32);

    always_comb begin
        w_state_d  = w_state_q;
        w_id_d     = w_id_q;
        w_addr_d   = w_addr_q;
        w_len_d    = w_len_q;
        w_cnt_d    = w_cnt_q;
        w_berr_d   = w_berr_q;
        w_slverr_d = w_slverr_q;
        w_we       = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (S_AXI_AWVALID && awready_q) begin
                    w_id_d     = S_AXI_AWID;
                    w_addr_d   = S_AXI_AWADDR;
                    w_len_d    = S_AXI_AWLEN;
                    w_cnt_d    = '0;
                    w_berr_d   = (S_AXI_AWSIZE != 3'b010) || (S_AXI_AWBURST != 2'b01);
                    w_slverr_d = 1'b0;
                    w_state_d  = W_DATA;
                end
            end
            W_DATA: begin
                if (S_AXI_WVALID) begin
                    if (w_in_range && !w_berr_q && (w_cnt_q <= {1'b0, w_len_q})) begin
                        w_we = 1'b1;
                    end else begin
                        w_slverr_d = 1'b1;
                    end
                    w_addr_d = w_addr_q + 32'd4;
                    // Saturate so an overlong burst can never wrap back into the legal window.
                    if (w_cnt_q != '1) begin
                        w_cnt_d = w_cnt_q + 9'd1;
                    end
                    if (S_AXI_WLAST) begin
                        if (w_cnt_q != {1'b0, w_len_q}) begin
                            w_slverr_d = 1'b1;
                        end
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            w_state_q  <= W_IDLE;
            awready_q  <= 1'b0;
            w_id_q     <= 1'b0;
            w_addr_q   <= '0;
            w_len_q    <= '0;
            w_cnt_q    <= '0;
            w_berr_q   <= 1'b0;
            w_slverr_q <= 1'b0;
        end else begin
            w_state_q  <= w_state_d;
            awready_q  <= (w_state_d == W_IDLE);
            w_id_q     <= w_id_d;
            w_addr_q   <= w_addr_d;
            w_len_q    <= w_len_d;
            w_cnt_q    <= w_cnt_d;
            w_berr_q   <= w_berr_d;
            w_slverr_q <= w_slverr_d;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        r_berr_d  = r_berr_q;
        r_ok_d    = r_ok_q;
        case (r_state_q)
            R_IDLE: begin
                if (S_AXI_ARVALID && arready_q) begin
                    r_id_d    = S_AXI_ARID;
                    r_addr_d  = S_AXI_ARADDR;
                    r_len_d   = S_AXI_ARLEN;
                    r_cnt_d   = '0;
                    r_berr_d  = (S_AXI_ARSIZE != 3'b010) || (S_AXI_ARBURST != 2'b01);
                    r_state_d = R_FETCH;
                end
            end
            R_FETCH: begin
                r_ok_d    = r_in_range && !r_berr_q;
                r_state_d = R_DATA;
            end
            R_DATA: begin
                if (S_AXI_RREADY) begin
                    if (r_cnt_q == r_len_q) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_addr_d  = r_addr_q + 32'd4;
                        r_cnt_d   = r_cnt_q + 8'd1;
                        r_state_d = R_FETCH;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            r_id_q    <= 1'b0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_berr_q  <= 1'b0;
            r_ok_q    <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= (r_state_d == R_IDLE);
            r_id_q    <= r_id_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_berr_q  <= r_berr_d;
            r_ok_q    <= r_ok_d;
        end
    end

    // Nonblocking read and write in the same block give read-before-write on a collision.
    always_ff @(posedge CLK) begin
        if (w_we) begin
            for (int b = 0; b < 4; b++) begin
                if (S_AXI_WSTRB[b]) begin
                    mem[w_off[IDX_W+1:2]][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
                end
            end
        end
        if (r_state_q == R_FETCH) begin
            mem_rd_q <= mem[r_off[IDX_W+1:2]];
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = (w_state_q == W_DATA);
    assign S_AXI_BVALID  = (w_state_q == W_RESP);
    assign S_AXI_BID     = S_AXI_BVALID ? w_id_q : 1'b0;
    assign S_AXI_BRESP   = (S_AXI_BVALID && (w_berr_q || w_slverr_q)) ? 2'b10 : 2'b00;

    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = (r_state_q == R_DATA);
    assign S_AXI_RID     = S_AXI_RVALID ? r_id_q : 1'b0;
    assign S_AXI_RDATA   = (S_AXI_RVALID && r_ok_q) ? mem_rd_q : 32'h0;
    assign S_AXI_RRESP   = (S_AXI_RVALID && !r_ok_q) ? 2'b10 : 2'b00;
    assign S_AXI_RLAST   = S_AXI_RVALID && (r_cnt_q == r_len_q);

endmodule
`default_nettype wire

// File: tb/tb_axi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_mem_responder
// Brief    : Directed self-checking bench for axi_mem_responder.
// Revision : 1.0
// ============================================================================
module tb_axi_mem_responder;
    localparam int unsigned MEM_WORDS = 256;
    localparam logic [31:0] BASE_ADDR = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        S_AXI_AWID = 1'b0;
    logic [31:0] S_AXI_AWADDR = '0;
    logic [7:0]  S_AXI_AWLEN = '0;
    logic [2:0]  S_AXI_AWSIZE = 3'b010;
    logic [1:0]  S_AXI_AWBURST = 2'b01;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_WLAST = 1'b0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic        S_AXI_BID;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b0;
    logic        S_AXI_ARID = 1'b0;
    logic [31:0] S_AXI_ARADDR = '0;
    logic [7:0]  S_AXI_ARLEN = '0;
    logic [2:0]  S_AXI_ARSIZE = 3'b010;
    logic [1:0]  S_AXI_ARBURST = 2'b01;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic        S_AXI_RID;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RLAST;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [31:0] rd_data [8];
    logic [1:0]  rd_resp [8];
    logic        rd_last [8];
    logic        rd_id;
    int          rd_lat;
    int          rd_beats;
    logic [1:0]  bresp;
    logic        bid;

    axi_mem_responder #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE_ADDR)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
        .S_AXI_AWSIZE(S_AXI_AWSIZE), .S_AXI_AWBURST(S_AXI_AWBURST),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
        .S_AXI_ARSIZE(S_AXI_ARSIZE), .S_AXI_ARBURST(S_AXI_ARBURST),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Beats carry d0, d0+1, ...; bhold keeps BREADY low for that many cycles once BVALID is up.
    task automatic write_burst(input logic id, input logic [31:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input int nbeats, input logic [31:0] d0,
                               input logic [3:0] strb, input int bhold,
                               output logic [1:0] resp, output logic rid);
        int t;
        S_AXI_AWID = id; S_AXI_AWADDR = addr; S_AXI_AWLEN = len;
        S_AXI_AWSIZE = size; S_AXI_AWBURST = 2'b01; S_AXI_AWVALID = 1'b1;
        t = 0;
        while (!S_AXI_AWREADY && t < 50) begin @(negedge CLK); t++; end
        chk("aw_ready", S_AXI_AWREADY, 1);
        @(negedge CLK);
        S_AXI_AWVALID = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            S_AXI_WDATA = d0 + i; S_AXI_WSTRB = strb;
            S_AXI_WLAST = (i == nbeats - 1); S_AXI_WVALID = 1'b1;
            t = 0;
            while (!S_AXI_WREADY && t < 50) begin @(negedge CLK); t++; end
            @(negedge CLK);
        end
        S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
        t = 0;
        while (!S_AXI_BVALID && t < 50) begin @(negedge CLK); t++; end
        for (int i = 0; i < bhold; i++) begin
            chk("bhold_bvalid", S_AXI_BVALID, 1);
            chk("bhold_awready", S_AXI_AWREADY, 0);
            @(negedge CLK);
        end
        chk("b_valid", S_AXI_BVALID, 1);
        resp = S_AXI_BRESP; rid = S_AXI_BID;
        S_AXI_BREADY = 1'b1;
        @(negedge CLK);
        S_AXI_BREADY = 1'b0;
    endtask

    // pat[k%4] drives RREADY on the k-th cycle after the first RVALID.
    task automatic read_burst(input logic id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [3:0] pat);
        int t;
        int k;
        logic stall;
        logic [31:0] held;
        S_AXI_ARID = id; S_AXI_ARADDR = addr; S_AXI_ARLEN = len;
        S_AXI_ARSIZE = size; S_AXI_ARBURST = 2'b01; S_AXI_ARVALID = 1'b1;
        t = 0;
        while (!S_AXI_ARREADY && t < 50) begin @(negedge CLK); t++; end
        chk("ar_ready", S_AXI_ARREADY, 1);
        @(negedge CLK);
        S_AXI_ARVALID = 1'b0;
        rd_lat = 1;
        while (!S_AXI_RVALID && rd_lat < 50) begin @(negedge CLK); rd_lat++; end
        rd_beats = 0; k = 0; stall = 1'b0; held = '0;
        while (rd_beats <= int'(len) && k < 200) begin
            S_AXI_RREADY = pat[k % 4];
            if (stall) begin
                chk("r_stall_valid", S_AXI_RVALID, 1);
                chk("r_stall_data", S_AXI_RDATA, held);
            end
            stall = 1'b0;
            if (S_AXI_RVALID) begin
                if (S_AXI_RREADY) begin
                    rd_data[rd_beats] = S_AXI_RDATA;
                    rd_resp[rd_beats] = S_AXI_RRESP;
                    rd_last[rd_beats] = S_AXI_RLAST;
                    rd_id = S_AXI_RID;
                    rd_beats++;
                end else begin
                    stall = 1'b1;
                    held = S_AXI_RDATA;
                end
            end
            k++;
            @(negedge CLK);
        end
        S_AXI_RREADY = 1'b0;
        chk("r_beats", rd_beats, 32'(len) + 32'd1);
    endtask

    initial begin
        logic [1:0] bresp2;
        logic       bid2;
        int         t;

        repeat (3) @(negedge CLK);
        chk("rst_readies", {S_AXI_AWREADY, S_AXI_ARREADY, S_AXI_WREADY}, 0);
        chk("rst_valids", {S_AXI_BVALID, S_AXI_RVALID, S_AXI_RLAST}, 0);
        chk("rst_rdata", S_AXI_RDATA, 0);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("rel_awready", S_AXI_AWREADY, 1);
        chk("rel_arready", S_AXI_ARREADY, 1);

        write_burst(1'b1, 32'h10, 8'd0, 3'b010, 1, 32'hDEADBEEF, 4'hF, 0, bresp, bid);
        chk("w1_bresp", bresp, 2'b00);
        chk("w1_bid", bid, 1);
        read_burst(1'b1, 32'h10, 8'd0, 3'b010, 4'b1111);
        chk("r1_data", rd_data[0], 32'hDEADBEEF);
        chk("r1_last", rd_last[0], 1);
        chk("r1_resp", rd_resp[0], 2'b00);
        chk("r1_id", rd_id, 1);
        chk("r1_latency", rd_lat, 2);

        write_burst(1'b0, 32'h20, 8'd0, 3'b010, 1, 32'h11223344, 4'hF, 0, bresp, bid);
        write_burst(1'b0, 32'h20, 8'd0, 3'b010, 1, 32'hAABBCCDD, 4'b0101, 0, bresp, bid);
        chk("strb_bresp", bresp, 2'b00);
        read_burst(1'b0, 32'h20, 8'd0, 3'b010, 4'b1111);
        chk("strb_data", rd_data[0], 32'h11BB33DD);

        write_burst(1'b0, 32'h40, 8'd3, 3'b010, 4, 32'h1, 4'hF, 0, bresp, bid);
        chk("burst_bresp", bresp, 2'b00);
        read_burst(1'b0, 32'h40, 8'd3, 3'b010, 4'b1001);
        for (int i = 0; i < 4; i++) begin
            chk("burst_data", rd_data[i], 32'(i + 1));
            chk("burst_last", rd_last[i], (i == 3) ? 32'd1 : 32'd0);
            chk("burst_resp", rd_resp[i], 2'b00);
        end

        write_burst(1'b0, 32'h10, 8'd0, 3'b001, 1, 32'h12345678, 4'hF, 0, bresp, bid);
        chk("size_err_bresp", bresp, 2'b10);
        read_burst(1'b0, 32'h10, 8'd0, 3'b010, 4'b1111);
        chk("size_err_ram_kept", rd_data[0], 32'hDEADBEEF);
        read_burst(1'b0, 32'h10, 8'd0, 3'b001, 4'b1111);
        chk("rsize_err_resp", rd_resp[0], 2'b10);
        chk("rsize_err_data", rd_data[0], 0);

        read_burst(1'b1, BASE_ADDR + 4 * MEM_WORDS, 8'd0, 3'b010, 4'b1111);
        chk("oor_resp", rd_resp[0], 2'b10);
        chk("oor_data", rd_data[0], 0);
        chk("oor_last", rd_last[0], 1);
        read_burst(1'b0, BASE_ADDR + 4 * MEM_WORDS - 4, 8'd1, 3'b010, 4'b1111);
        chk("straddle_resp0", rd_resp[0], 2'b00);
        chk("straddle_resp1", rd_resp[1], 2'b10);
        chk("straddle_data1", rd_data[1], 0);

        write_burst(1'b1, 32'h60, 8'd1, 3'b010, 1, 32'h55, 4'hF, 0, bresp, bid);
        chk("short_bresp", bresp, 2'b10);
        chk("short_bid", bid, 1);

        fork
            write_burst(1'b1, 32'h80, 8'd1, 3'b010, 2, 32'hA0, 4'hF, 0, bresp2, bid2);
            read_burst(1'b0, 32'h40, 8'd3, 3'b010, 4'b1111);
        join
        chk("conc_bresp", bresp2, 2'b00);
        for (int i = 0; i < 4; i++) chk("conc_rdata", rd_data[i], 32'(i + 1));
        read_burst(1'b0, 32'h80, 8'd1, 3'b010, 4'b1111);
        chk("conc_wdata0", rd_data[0], 32'hA0);
        chk("conc_wdata1", rd_data[1], 32'hA1);

        write_burst(1'b0, 32'h90, 8'd0, 3'b010, 1, 32'h77, 4'hF, 5, bresp, bid);
        chk("bhold_bresp", bresp, 2'b00);
        @(negedge CLK);
        chk("bhold_awready_back", S_AXI_AWREADY, 1);

        S_AXI_ARID = 1'b0; S_AXI_ARADDR = 32'h40; S_AXI_ARLEN = 8'd3;
        S_AXI_ARSIZE = 3'b010; S_AXI_ARBURST = 2'b01; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
        t = 0;
        while (!S_AXI_ARREADY && t < 50) begin @(negedge CLK); t++; end
        @(negedge CLK);
        S_AXI_ARVALID = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_pre_rvalid", S_AXI_RVALID, 1);
        #2 RST_N = 1'b0;
        #1;
        chk("rst_async_rvalid", S_AXI_RVALID, 0);
        chk("rst_async_arready", S_AXI_ARREADY, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        chk("rst_release_arready_low", S_AXI_ARREADY, 0);
        @(negedge CLK);
        chk("rst_release_arready", S_AXI_ARREADY, 1);
        read_burst(1'b1, 32'h20, 8'd0, 3'b010, 4'b1111);
        chk("post_rst_data", rd_data[0], 32'h11BB33DD);
        chk("post_rst_resp", rd_resp[0], 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_mem_responder.md
Name: axi_mem_responder

Overview:
AXI4 slave (responder) backed by a word-addressed internal RAM. It is the memory-side counterpart of the core's AXI initiator, used for simulation and on-chip scratch memory. It serves 32-bit INCR bursts on independent read and write channels, byte-enable writes, and returns SLVERR for unsupported or out-of-range accesses.

Parameters:
MEM_WORDS, 1024, RAM depth in 32-bit words (power of 2, ≥4)
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be word aligned

Ports:
CLK  in  1  clock
RST_N  in  1  asynchronous active-low reset
S_AXI_AWID  in  1  write ID
S_AXI_AWADDR  in  32  write start byte address
S_AXI_AWLEN  in  8  write beats minus 1
S_AXI_AWSIZE  in  3  beat size; only 3'b010 is legal
S_AXI_AWBURST  in  2  burst type; only 2'b01 (INCR) is legal
S_AXI_AWVALID  in  1  AW valid
S_AXI_AWREADY  out  1  AW ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WLAST  in  1  last write beat
S_AXI_WVALID  in  1  W valid
S_AXI_WREADY  out  1  W ready
S_AXI_BID  out  1  response ID (echoes AWID)
S_AXI_BRESP  out  2  2'b00 OKAY / 2'b10 SLVERR
S_AXI_BVALID  out  1  B valid
S_AXI_BREADY  in  1  B ready (initiators without BREADY tie this to 1)
S_AXI_ARID, ARADDR, ARLEN, ARSIZE, ARBURST  in  1/32/8/3/2  same meaning as the AW fields
S_AXI_ARVALID  in  1  AR valid
S_AXI_ARREADY  out  1  AR ready
S_AXI_RID  out  1  echoes ARID
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  OKAY/SLVERR
S_AXI_RLAST  out  1  last read beat
S_AXI_RVALID  out  1  R valid
S_AXI_RREADY  in  1  R ready (initiators without RREADY tie this to 1)

Behaviour:
- Reset (RST_N=0, asynchronous): all outputs 0. Both FSMs go to IDLE. Beat counters clear. RAM contents are not reset.
- Reset mid-burst: the burst is abandoned immediately, with no B or R response. Partial writes already committed stay in RAM.
- Word index = (addr - BASE_ADDR) >> 2. A beat is in range iff addr ≥ BASE_ADDR and index < MEM_WORDS. Address increments by 4 per beat. No wrap-around and no 4KB-boundary check.
- Burst error: AxSIZE != 3'b010 or AxBURST != 2'b01 marks the whole burst SLVERR. Such a burst has no RAM effect and returns RDATA=0.
- Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: AWREADY=1. On AWVALID&&AWREADY, latch ID/addr/len/error, clear the beat count, go to W_DATA (AWREADY=0).
  - W_DATA: WREADY=1. Each WVALID&&WREADY beat writes the bytes where WSTRB=1 if the beat is in range, burst is OK, and beat count ≤ AWLEN; otherwise the beat is dropped and the SLVERR flag is set.
  - On the WLAST beat: set SLVERR if beat count != AWLEN, then go to W_RESP with WREADY=0.
  - W_RESP: BVALID=1, BID=latched ID, BRESP per flag. Hold until BREADY, then return to W_IDLE. AWREADY reasserts the following cycle.
- Read FSM: R_IDLE -> R_FETCH -> R_DATA.
  - R_IDLE: ARREADY=1. On handshake, latch fields and go to R_FETCH (ARREADY=0).
  - R_FETCH: synchronous RAM read of the current address (one cycle).
  - R_DATA: RVALID=1, RDATA=RAM word (0 if out of range or error), RRESP per beat, RLAST=1 when beat count == ARLEN. RID/RDATA/RRESP/RLAST stay stable while RVALID && !RREADY.
  - On handshake: if not last, increment address and count and go to R_FETCH; if last, go to R_IDLE.
  - Timing: first RVALID two cycles after the AR handshake; throughput is 1 beat per 2 cycles.
- Read and write FSMs run concurrently (dual-port RAM). A same-cycle read and write of the same word returns the old data (read-before-write).
- Out-of-range beats within an otherwise legal read burst return SLVERR for that beat only.

Test Plan:
- Reset release, single write: AWADDR=0x10, AWLEN=0, WDATA=0xDEADBEEF, WSTRB=4'hF, WLAST=1 -> BVALID with BRESP=00 and BID=AWID. A following single read at 0x10 -> RDATA=0xDEADBEEF, RLAST=1, RRESP=00; RVALID rises 2 cycles after the AR handshake.
- Byte strobes: write 0x11223344 to 0x20, then WDATA=0xAABBCCDD with WSTRB=4'b0101 -> read at 0x20 returns 0x11BB33DD.
- Burst with backpressure: AWLEN=3 writes 1,2,3,4 to 0x40; read back with ARLEN=3 while RREADY toggles 1,0,0,1 -> data 1..4 in order, held stable while stalled, RLAST only on the 4th beat.
- Errors: AWSIZE=3'b001 -> BRESP=10 and RAM unchanged. Read at BASE_ADDR+4*MEM_WORDS -> RRESP=10, RDATA=0. AWLEN=1 with WLAST on beat 0 -> BRESP=10.
- Concurrency/BREADY hold: a write burst and a read burst issued in the same cycle both complete with correct data. With BREADY held 0 for 5 cycles, BVALID stays 1 and AWREADY stays 0.
- Async reset mid read burst (RST_N low between clock edges) -> RVALID=0 and ARREADY=0 immediately. After release, ARREADY=1 on the first edge and a new read succeeds.
